// File: rtl/memsplit_dma_pkg.sv
// Shared types and constants for the split-bus DMA engine: FSM state
// encoding, full-word byte enable and the per-word address stride.
package memsplit_dma_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      FINISH
   } state_t;

   localparam logic [3:0]  BE_FULL     = 4'hF;
   localparam logic [31:0] ADDR_STRIDE = 32'd4;

endpackage

// File: rtl/memsplit_dma_bus.sv
// Split-transaction memory bus: request/ack handshake with a separate
// read response (resp + rdata) that arrives after the ack.
interface MemSplit32;

   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        ack;
   logic        resp;
   logic [31:0] rdata;

   modport Master (
      output req, we, addr, be, wdata,
      input  ack, resp, rdata
   );

   modport Slave (
      input  req, we, addr, be, wdata,
      output ack, resp, rdata
   );

endinterface

// File: rtl/memsplit_dma_wdt.sv
// Read-response watchdog: counts enabled cycles since the last clear and
// flags expiry on the TIMEOUT_CYCLES-th enabled cycle.
module memsplit_dma_wdt #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

   // Count starts at zero in the first waiting cycle, so TIMEOUT_CYCLES-1 marks the last one.
   assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/memsplit_dma.sv
// Word-by-word copy engine on a split read/write bus: one read, wait for its
// response, one write, repeat; aborts when a read response never arrives.
module memsplit_dma
   import memsplit_dma_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int LEN_WIDTH      = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   MemSplit32.Master            bus,
   input  logic                 start_i,
   input  logic [31:0]          src_addr_bi,
   input  logic [31:0]          dst_addr_bi,
   input  logic [LEN_WIDTH-1:0] len_bi,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [LEN_WIDTH-1:0] words_done_bo
);

   state_t               state, state_n;
   logic [31:0]          src, src_n;
   logic [31:0]          dst, dst_n;
   logic [31:0]          data, data_n;
   logic [LEN_WIDTH-1:0] xfer_len, xfer_len_n;
   logic [LEN_WIDTH-1:0] count, count_n;
   logic                 err_n;
   logic                 req_n;
   logic                 wdt_clear;
   logic                 wdt_enable;
   logic                 wdt_expired;

   memsplit_dma_wdt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clear  (wdt_clear),
      .enable (wdt_enable),
      .expired(wdt_expired)
   );

   assign wdt_enable    = (state == RD_WAIT);
   assign busy_o        = (state != IDLE);
   assign words_done_bo = count;

   always_comb begin
      state_n    = state;
      src_n      = src;
      dst_n      = dst;
      data_n     = data;
      xfer_len_n = xfer_len;
      count_n    = count;
      err_n      = 1'b0;
      wdt_clear  = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               src_n      = src_addr_bi & 32'hFFFF_FFFC;
               dst_n      = dst_addr_bi & 32'hFFFF_FFFC;
               xfer_len_n = len_bi;
               count_n    = '0;
               state_n    = (len_bi == '0) ? FINISH : RD_REQ;
            end
         end
         RD_REQ: begin
            if (bus.ack) begin
               wdt_clear = 1'b1;
               state_n   = RD_WAIT;
            end
         end
         RD_WAIT: begin
            // A response on the final allowed cycle still wins over the abort.
            if (bus.resp) begin
               data_n  = bus.rdata;
               state_n = WR_REQ;
            end else if (wdt_expired) begin
               err_n   = 1'b1;
               state_n = IDLE;
            end
         end
         WR_REQ: begin
            if (bus.ack) begin
               count_n = count + 1'b1;
               src_n   = src + ADDR_STRIDE;
               dst_n   = dst + ADDR_STRIDE;
               state_n = (count_n == xfer_len) ? FINISH : RD_REQ;
            end
         end
         FINISH: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign req_n = (state_n == RD_REQ) || (state_n == WR_REQ);

   // Bus outputs are registered from the next-state values, so they only move
   // on a state or address change and hold while a request waits for ack.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         src       <= '0;
         dst       <= '0;
         data      <= '0;
         xfer_len  <= '0;
         count     <= '0;
         done_o    <= 1'b0;
         err_o     <= 1'b0;
         bus.req   <= 1'b0;
         bus.we    <= 1'b0;
         bus.be    <= 4'h0;
         bus.addr  <= '0;
         bus.wdata <= '0;
      end else begin
         state     <= state_n;
         src       <= src_n;
         dst       <= dst_n;
         data      <= data_n;
         xfer_len  <= xfer_len_n;
         count     <= count_n;
         done_o    <= (state == FINISH);
         err_o     <= err_n;
         bus.req   <= req_n;
         bus.we    <= (state_n == WR_REQ);
         bus.be    <= req_n ? BE_FULL : 4'h0;
         bus.addr  <= (state_n == WR_REQ) ? dst_n : src_n;
         bus.wdata <= data_n;
      end
   end

endmodule
